// File: rtl/jtframe_inputs.sv
// jtframe_inputs: conditions user-I/O joystick, coin, start and pause keys for a game core.
// Per-bit debounce, one fixed-length coin pulse per press, pause toggle.
// Optional per-button autofire when JTFRAME_AUTOFIRE_EN is defined.
module jtframe_inputs #(
  parameter int unsigned PLAYERS  = 2,
  parameter int unsigned BUTTONS  = 3,
  parameter int unsigned DEB_LEN  = 4,
  parameter int unsigned COIN_LEN = 8,
  parameter int unsigned AF_HALF  = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cen,
  input  logic [PLAYERS*(4+BUTTONS)-1:0] joy_raw,
  input  logic [PLAYERS-1:0]           coin_raw,
  input  logic [PLAYERS-1:0]           start_raw,
  input  logic                         pause_raw,
  input  logic [PLAYERS*BUTTONS-1:0]   autofire_sel,
  output logic [PLAYERS*(4+BUTTONS)-1:0] game_joy,
  output logic [PLAYERS-1:0]           game_coin,
  output logic [PLAYERS-1:0]           game_start,
  output logic                         game_pause
);

  localparam int unsigned JW = 4 + BUTTONS;
  localparam int unsigned PJ = PLAYERS * JW;
  localparam int unsigned NB = PJ + 2 * PLAYERS + 1;
  localparam int unsigned DW = $clog2(DEB_LEN);
  localparam int unsigned CW = $clog2(COIN_LEN + 1);

  localparam logic [DW-1:0] DebMax   = DW'(DEB_LEN - 1);
  localparam logic [CW-1:0] CoinLoad = CW'(COIN_LEN);
  localparam logic [CW-1:0] CoinOne  = CW'(1);

  typedef enum logic [1:0] {StIdle, StPulse, StHold} coin_st_e;

  // Raw bit order: joy, coin, start, pause
  logic [NB-1:0] raw, d_q, d_d;
  logic [DW-1:0] cnt_q [NB];
  logic [DW-1:0] cnt_d [NB];

  assign raw = {pause_raw, start_raw, coin_raw, joy_raw};

  // Debounce: accept a new level after DEB_LEN consecutive differing samples
  always_comb begin
    d_d = d_q;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (cen) begin
        if (raw[i] == d_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == DebMax) begin
          d_d[i]   = raw[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Debounce state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
    end else begin
      d_q <= d_d;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  logic [PLAYERS-1:0] coin_lvl_q, coin_lvl_d, coin_rise;
  assign coin_lvl_q = d_q[PJ +: PLAYERS];
  assign coin_lvl_d = d_d[PJ +: PLAYERS];
  assign coin_rise  = coin_lvl_d & ~coin_lvl_q;

  coin_st_e           coin_st_q [PLAYERS];
  coin_st_e           coin_st_d [PLAYERS];
  logic [CW-1:0]      coin_cnt_q [PLAYERS];
  logic [CW-1:0]      coin_cnt_d [PLAYERS];
  // A key held through reset is not a new press: arm only after a released sample
  logic [PLAYERS-1:0] arm_q, arm_d;

  // Coin FSM next state: one pulse per debounced press
  always_comb begin
    arm_d = arm_q;
    for (int p = 0; p < PLAYERS; p++) begin
      coin_st_d[p]  = coin_st_q[p];
      coin_cnt_d[p] = coin_cnt_q[p];
      if (cen) begin
        if (!coin_raw[p] && !coin_lvl_d[p]) arm_d[p] = 1'b1;
        case (coin_st_q[p])
          StIdle: begin
            if (coin_rise[p] && arm_q[p]) begin
              coin_st_d[p]  = StPulse;
              coin_cnt_d[p] = CoinLoad;
            end
          end
          StPulse: begin
            if (coin_cnt_q[p] <= CoinOne) coin_st_d[p] = StHold;
            else coin_cnt_d[p] = coin_cnt_q[p] - 1'b1;
          end
          StHold: begin
            if (!coin_lvl_d[p]) coin_st_d[p] = StIdle;
          end
          default: coin_st_d[p] = StIdle;
        endcase
      end
    end
  end

  // Coin FSM state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q <= '0;
      for (int p = 0; p < PLAYERS; p++) begin
        coin_st_q[p]  <= StIdle;
        coin_cnt_q[p] <= '0;
      end
    end else begin
      arm_q <= arm_d;
      for (int p = 0; p < PLAYERS; p++) begin
        coin_st_q[p]  <= coin_st_d[p];
        coin_cnt_q[p] <= coin_cnt_d[p];
      end
    end
  end

  // Coin output is low only while pulsing, so reset releases it at once
  always_comb begin
    game_coin = '1;
    for (int p = 0; p < PLAYERS; p++) begin
      if (coin_st_q[p] == StPulse) game_coin[p] = 1'b0;
    end
  end

  logic pause_q;
  // Pause toggles on each debounced rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pause_q <= 1'b0;
    else if (d_d[NB-1] && !d_q[NB-1]) pause_q <= ~pause_q;
  end

  assign game_pause = pause_q;
  assign game_start = ~d_q[PJ+PLAYERS +: PLAYERS];

`ifdef JTFRAME_AUTOFIRE_EN
  localparam int unsigned AW = $clog2(AF_HALF + 1);
  localparam logic [AW-1:0] AfLoad = AW'(AF_HALF);
  localparam logic [AW-1:0] AfOne  = AW'(1);

  logic [PLAYERS-1:0] phase_q, phase_d;
  logic [AW-1:0]      af_cnt_q [PLAYERS];
  logic [AW-1:0]      af_cnt_d [PLAYERS];

  // Autofire phase: restart on any enabled press, toggle every AF_HALF ticks while held
  always_comb begin
    phase_d = phase_q;
    for (int p = 0; p < PLAYERS; p++) begin
      af_cnt_d[p] = af_cnt_q[p];
      if (cen) begin
        if (|(autofire_sel[p*BUTTONS +: BUTTONS] & d_d[p*JW+4 +: BUTTONS]
              & ~d_q[p*JW+4 +: BUTTONS])) begin
          af_cnt_d[p] = AfLoad;
          phase_d[p]  = 1'b0;
        end else if (|(autofire_sel[p*BUTTONS +: BUTTONS] & d_q[p*JW+4 +: BUTTONS])) begin
          if (af_cnt_q[p] <= AfOne) begin
            af_cnt_d[p] = AfLoad;
            phase_d[p]  = ~phase_q[p];
          end else begin
            af_cnt_d[p] = af_cnt_q[p] - 1'b1;
          end
        end
      end
    end
  end

  // Autofire state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
      for (int p = 0; p < PLAYERS; p++) af_cnt_q[p] <= '0;
    end else begin
      phase_q <= phase_d;
      for (int p = 0; p < PLAYERS; p++) af_cnt_q[p] <= af_cnt_d[p];
    end
  end

  // Held autofire buttons follow the phase; everything else is the inverted level
  always_comb begin
    game_joy = ~d_q[PJ-1:0];
    for (int p = 0; p < PLAYERS; p++) begin
      for (int b = 0; b < BUTTONS; b++) begin
        if (autofire_sel[p*BUTTONS+b] && d_q[p*JW+4+b]) game_joy[p*JW+4+b] = phase_q[p];
      end
    end
  end
`else
  logic unused_autofire_sel;
  assign unused_autofire_sel = ^autofire_sel;
  assign game_joy = ~d_q[PJ-1:0];
`endif

endmodule

// File: tb/tb_jtframe_inputs.sv
// Bench for jtframe_inputs: directed scenarios plus randomized stimulus against a behavioural model.
module tb_jtframe_inputs;
  localparam int P  = 2;
  localparam int B  = 3;
  localparam int DL = 4;
  localparam int CL = 8;
  localparam int AH = 3;
  localparam int JW = 4 + B;
  localparam int PJ = P * JW;
  localparam int NB = PJ + 2 * P + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cen = 1'b0;
  logic [PJ-1:0] joy_raw = '0;
  logic [P-1:0]  coin_raw = '0;
  logic [P-1:0]  start_raw = '0;
  logic          pause_raw = 1'b0;
  logic [P*B-1:0] autofire_sel = '0;
  logic [PJ-1:0] game_joy;
  logic [P-1:0]  game_coin;
  logic [P-1:0]  game_start;
  logic          game_pause;

  jtframe_inputs #(
    .PLAYERS (P),
    .BUTTONS (B),
    .DEB_LEN (DL),
    .COIN_LEN(CL),
    .AF_HALF (AH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cen         (cen),
    .joy_raw     (joy_raw),
    .coin_raw    (coin_raw),
    .start_raw   (start_raw),
    .pause_raw   (pause_raw),
    .autofire_sel(autofire_sel),
    .game_joy    (game_joy),
    .game_coin   (game_coin),
    .game_start  (game_start),
    .game_pause  (game_pause)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: debounced level, count of consecutive differing samples,
  // remaining coin pulse ticks, hold flag, arm flag, pause, ticks held since autofire press.
  bit md [NB];
  int mrun [NB];
  int mleft [P];
  bit mhold [P];
  bit marm [P];
  bit mpause;
  int msince [P];

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      md[i] = 0;
      mrun[i] = 0;
    end
    for (int p = 0; p < P; p++) begin
      mleft[p] = 0;
      mhold[p] = 0;
      marm[p] = 0;
      msince[p] = 0;
    end
    mpause = 0;
  endtask

  task automatic model_tick();
    logic [NB-1:0] rv;
    bit old [NB];
    bit armed, rise, any_rise, any_held;
    int idx;
    if (!cen || !rst_n) return;
    rv = {pause_raw, start_raw, coin_raw, joy_raw};
    for (int i = 0; i < NB; i++) begin
      old[i] = md[i];
      if (rv[i] != md[i]) begin
        mrun[i]++;
        if (mrun[i] == DL) begin
          md[i] = rv[i];
          mrun[i] = 0;
        end
      end else begin
        mrun[i] = 0;
      end
    end
    for (int p = 0; p < P; p++) begin
      idx = PJ + p;
      rise = md[idx] && !old[idx];
      armed = marm[p];
      if (!rv[idx] && !md[idx]) marm[p] = 1;
      if (mleft[p] > 0) begin
        mleft[p]--;
        if (mleft[p] == 0) mhold[p] = 1;
      end else if (mhold[p]) begin
        if (!md[idx]) mhold[p] = 0;
      end else if (rise && armed) begin
        mleft[p] = CL;
      end
      any_rise = 0;
      any_held = 0;
      for (int b = 0; b < B; b++) begin
        if (autofire_sel[p*B+b]) begin
          if (md[p*JW+4+b] && !old[p*JW+4+b]) any_rise = 1;
          if (old[p*JW+4+b]) any_held = 1;
        end
      end
      if (any_rise) msince[p] = 0;
      else if (any_held) msince[p]++;
    end
    if (md[NB-1] && !old[NB-1]) mpause = !mpause;
  endtask

  function automatic logic [PJ-1:0] exp_joy();
    logic [PJ-1:0] e;
    for (int i = 0; i < PJ; i++) e[i] = !md[i];
`ifdef JTFRAME_AUTOFIRE_EN
    for (int p = 0; p < P; p++) begin
      for (int b = 0; b < B; b++) begin
        if (autofire_sel[p*B+b] && md[p*JW+4+b]) e[p*JW+4+b] = ((msince[p] / AH) % 2) == 1;
      end
    end
`endif
    return e;
  endfunction

  function automatic logic [P-1:0] exp_coin();
    logic [P-1:0] e;
    for (int p = 0; p < P; p++) e[p] = !(mleft[p] > 0);
    return e;
  endfunction

  function automatic logic [P-1:0] exp_start();
    logic [P-1:0] e;
    for (int p = 0; p < P; p++) e[p] = !md[PJ+P+p];
    return e;
  endfunction

  // One clock: advance the model on the edge, compare all outputs just after it
  task automatic step();
    @(posedge clk);
    model_tick();
    #1;
    check("joy", game_joy, exp_joy());
    check("coin", game_coin, exp_coin());
    check("start", game_start, exp_start());
    check("pause", game_pause, mpause);
  endtask

  task automatic do_reset(input logic [P*B-1:0] sel);
    #1;
    rst_n = 1'b0;
    autofire_sel = sel;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rmask(input int w);
    logic [31:0] m = '0;
    for (int i = 0; i < w; i++) if ($urandom_range(0, 11) == 0) m[i] = 1'b1;
    return m;
  endfunction

  int  lows, falls;
  bit  found, prev, expv;
  logic [31:0] tmp;

  initial begin
    cen = 1'b1;
    do_reset('0);
    check("rst_joy", game_joy, {PJ{1'b1}});
    check("rst_coin", game_coin, {P{1'b1}});
    check("rst_start", game_start, {P{1'b1}});
    check("rst_pause", game_pause, 1'b0);
    repeat (3) step();

    // Debounce: a 3-sample glitch is rejected, a held level lands on the 4th sample
    joy_raw[4] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("deb_glitch", game_joy[4], 1'b1);
    end
    joy_raw[4] = 1'b0;
    step();
    joy_raw[4] = 1'b1;
    for (int k = 1; k <= DL; k++) begin
      step();
      check("deb_latency", game_joy[4], (k == DL) ? 1'b0 : 1'b1);
    end
    joy_raw[4] = 1'b0;
    repeat (6) step();

    // Coin held 1000 cycles gives one pulse of CL ticks
    coin_raw[0] = 1'b1;
    lows = 0; falls = 0; prev = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (!game_coin[0]) lows++;
      if (prev && !game_coin[0]) falls++;
      prev = game_coin[0];
    end
    check("coin_len", lows, CL);
    check("coin_once", falls, 1);
    coin_raw[0] = 1'b0;
    repeat (10) step();
    coin_raw[0] = 1'b1;
    falls = 0; prev = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      if (prev && !game_coin[0]) falls++;
      prev = game_coin[0];
    end
    check("coin_repress", falls, 1);
    coin_raw[0] = 1'b0;
    repeat (10) step();

    // Simultaneous coins
    coin_raw = 2'b11;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (game_coin != 2'b11) found = 1'b1;
    end
    check("coin_sim_fall", game_coin, 2'b00);
    for (int k = 1; k < CL; k++) begin
      step();
      check("coin_sim_low", game_coin, 2'b00);
    end
    step();
    check("coin_sim_rise", game_coin, 2'b11);
    coin_raw = 2'b00;
    repeat (10) step();

    // Pause on, so the following reset has something to clear
    pause_raw = 1'b1;
    repeat (6) step();
    pause_raw = 1'b0;
    repeat (6) step();
    check("pause_on", game_pause, 1'b1);

    // Reset mid-pulse
    coin_raw[0] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (!game_coin[0]) found = 1'b1;
    end
    check("mid_pulse_start", game_coin[0], 1'b0);
    repeat (3) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_coin", game_coin, 2'b11);
    check("rst_async_pause", game_pause, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    lows = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!game_coin[0]) lows++;
    end
    check("rst_no_pulse", lows, 0);
    coin_raw[0] = 1'b0;
    repeat (10) step();

    // Pause 0 -> 1 -> 0, each change on the debounce edge
    for (int n = 0; n < 2; n++) begin
      pause_raw = 1'b1;
      for (int k = 1; k <= DL; k++) begin
        step();
        check("pause_edge", game_pause, (k == DL) ? (n == 0) : (n == 1));
      end
      pause_raw = 1'b0;
      repeat (6) step();
    end

    // Autofire on player 0 button 0
    do_reset(6'b000001);
    repeat (4) step();
    joy_raw[4] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      step();
      if (!game_joy[4]) found = 1'b1;
    end
    check("af_start", game_joy[4], 1'b0);
    for (int k = 1; k < 12; k++) begin
      step();
`ifdef JTFRAME_AUTOFIRE_EN
      expv = ((k / AH) % 2) == 1;
`else
      expv = 1'b0;
`endif
      check("af_seq", game_joy[4], expv);
    end
    joy_raw[4] = 1'b0;
    repeat (6) step();

    // Randomized segments, each with its own autofire selection
    for (int s = 0; s < 4; s++) begin
      tmp = $urandom;
      do_reset(tmp[P*B-1:0]);
      for (int k = 0; k < 600; k++) begin
        cen = ($urandom_range(0, 3) != 0);
        tmp = rmask(PJ);
        joy_raw = joy_raw ^ tmp[PJ-1:0];
        tmp = rmask(P);
        coin_raw = coin_raw ^ tmp[P-1:0];
        tmp = rmask(P);
        start_raw = start_raw ^ tmp[P-1:0];
        tmp = rmask(1);
        pause_raw = pause_raw ^ tmp[0];
        step();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
